// File: rtl/fe_packet_rx_buffer_pkg.sv
// fe_packet_rx_buffer_pkg: FE link constants, write-FSM states and a saturating-count helper.
package fe_packet_rx_buffer_pkg;
  localparam logic [15:0] FE_HEADER = 16'hDEAD;
  localparam int FE_PKT_WORDS = 128;
  typedef enum logic [1:0] {HUNT, RECV, DROP} wr_state_e;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v + 16'(v != 16'hFFFF);
  endfunction
endpackage

// File: rtl/fe_packet_rx_buffer_if.sv
// fe_packet_rx_buffer_if: receive stream, reorder-side pop port and status counters.
interface fe_packet_rx_buffer_if #(parameter int NUM_PKTS = 4) ();
  localparam int CW = $clog2(NUM_PKTS) + 1;
  logic [15:0] rx_data;
  logic rx_valid;
  logic pkt_ready;
  logic rd_req;
  logic [15:0] rd_data;
  logic [CW-1:0] pkts_stored;
  logic [15:0] drop_cnt;
  logic [15:0] trunc_cnt;
  modport master (output rx_data, rx_valid, rd_req, input pkt_ready, rd_data, pkts_stored, drop_cnt, trunc_cnt);
  modport slave (input rx_data, rx_valid, rd_req, output pkt_ready, rd_data, pkts_stored, drop_cnt, trunc_cnt);
endinterface

// File: rtl/fe_pkt_ram.sv
// fe_pkt_ram: simple dual-port packet store with a registered synchronous read.
module fe_pkt_ram #(
  parameter int DEPTH = 512,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic inclk,
  input  logic rst_n,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0] rdata
);
  logic [15:0] mem [DEPTH];
  always_ff @(posedge inclk) if (we) mem[waddr] <= wdata;
  always_ff @(posedge inclk) rdata <= rst_n ? mem[raddr] : '0;
endmodule

// File: rtl/fe_packet_rx_buffer.sv
// fe_packet_rx_buffer: hunts for FE packet headers, stores whole packets, and serves them show-ahead.
module fe_packet_rx_buffer
  import fe_packet_rx_buffer_pkg::*;
#(
  parameter int PKT_WORDS = FE_PKT_WORDS,
  parameter int NUM_PKTS = 4
) (
  input logic inclk,
  input logic rst_n,
  fe_packet_rx_buffer_if.slave bus
);
  localparam int DEPTH = PKT_WORDS * NUM_PKTS;
  localparam int AW = $clog2(DEPTH);
  localparam int WCW = $clog2(PKT_WORDS);
  localparam int CW = $clog2(NUM_PKTS) + 1;
  wr_state_e state;
  logic [AW-1:0] wr_ptr, commit_ptr, rd_ptr, waddr;
  logic [WCW-1:0] wcnt, rcnt;
  logic [CW-1:0] cnt, cnt_next;
  logic [15:0] drop_cnt, trunc_cnt, rd_data;
  logic pkt_ready, is_hdr, full, we, commit, pop, last_pop;
  // outside RECV wr_ptr equals commit_ptr, so every header lands at commit_ptr
  always_comb begin
    is_hdr = bus.rx_valid && bus.rx_data == FE_HEADER;
    full = cnt == CW'(NUM_PKTS);
    we = state == RECV ? bus.rx_valid : is_hdr && !full;
    waddr = is_hdr ? commit_ptr : wr_ptr;
    commit = state == RECV && bus.rx_valid && !is_hdr && wcnt == WCW'(PKT_WORDS - 1);
    pop = bus.rd_req && cnt != '0;
    last_pop = pop && rcnt == WCW'(PKT_WORDS - 1);
    cnt_next = cnt + CW'(commit) - CW'(last_pop);
  end
  always_ff @(posedge inclk) begin
    if (!rst_n) begin
      state <= HUNT;
      wr_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
      wcnt <= '0;
      rcnt <= '0;
      cnt <= '0;
      pkt_ready <= 1'b0;
      drop_cnt <= '0;
      trunc_cnt <= '0;
    end else begin
      cnt <= cnt_next;
      pkt_ready <= cnt_next != '0;
      rd_ptr <= rd_ptr + AW'(pop);
      if (pop) rcnt <= last_pop ? '0 : rcnt + WCW'(1);
      if (we) wr_ptr <= waddr + AW'(1);
      if (commit) commit_ptr <= wr_ptr + AW'(1);
      case (state)
        HUNT, DROP:
          if (is_hdr) begin
            wcnt <= WCW'(1);
            state <= full ? DROP : RECV;
            if (full) drop_cnt <= sat_inc(drop_cnt);
          end else if (state == DROP && bus.rx_valid) begin
            wcnt <= wcnt + WCW'(1);
            if (wcnt == WCW'(PKT_WORDS - 1)) state <= HUNT;
          end
        RECV:
          if (is_hdr) begin
            wcnt <= WCW'(1);
            trunc_cnt <= sat_inc(trunc_cnt);
          end else if (bus.rx_valid) begin
            wcnt <= wcnt + WCW'(1);
            if (commit) state <= HUNT;
          end
        default: state <= HUNT;
      endcase
    end
  end
  fe_pkt_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .inclk(inclk),
    .rst_n(rst_n),
    .we(we),
    .waddr(waddr),
    .wdata(bus.rx_data),
    .raddr(rd_ptr + AW'(pop)),
    .rdata(rd_data)
  );
  assign bus.pkt_ready = pkt_ready;
  assign bus.rd_data = rd_data;
  assign bus.pkts_stored = cnt;
  assign bus.drop_cnt = drop_cnt;
  assign bus.trunc_cnt = trunc_cnt;
endmodule

// File: tb/tb_fe_packet_rx_buffer.sv
// tb_fe_packet_rx_buffer: directed scenarios with a word scoreboard for fe_packet_rx_buffer.
module tb_fe_packet_rx_buffer;
  import fe_packet_rx_buffer_pkg::*;
  logic inclk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [15:0] q[$];
  always #5 inclk = ~inclk;
  fe_packet_rx_buffer_if bus ();
  fe_packet_rx_buffer dut (.inclk(inclk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] pw(input int tag, input int i);
    return i == 0 ? FE_HEADER : 16'((tag << 8) | i);
  endfunction
  task automatic put(input logic [15:0] d);
    bus.rx_valid = 1'b1;
    bus.rx_data = d;
    @(negedge inclk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic send_pkt(input int tag, input bit keep, input int gap);
    for (int i = 0; i < 128; i++) begin
      if (keep) q.push_back(pw(tag, i));
      put(pw(tag, i));
      repeat (gap) @(negedge inclk);
    end
  endtask
  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL scoreboard_underflow observed=%0d expected=%0d", k, n);
        break;
      end
      chk("rd_data", bus.rd_data, q.pop_front());
      bus.rd_req = 1'b1;
      @(negedge inclk);
    end
    bus.rd_req = 1'b0;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_pkt_ready"}, bus.pkt_ready, 0);
    chk({tag, "_rd_data"}, bus.rd_data, 0);
    chk({tag, "_pkts_stored"}, bus.pkts_stored, 0);
    chk({tag, "_drop_cnt"}, bus.drop_cnt, 0);
    chk({tag, "_trunc_cnt"}, bus.trunc_cnt, 0);
  endtask
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.rd_req = 1'b0;
    repeat (3) @(negedge inclk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge inclk);
    put(16'h1234);
    put(16'h5555);
    chk("garbage_ignored", bus.pkts_stored, 0);
    for (int i = 0; i < 128; i++) begin
      q.push_back(pw(0, i));
      if (i == 127) chk("ready_before_last", bus.pkt_ready, 0);
      put(pw(0, i));
    end
    chk("ready_at_128", bus.pkt_ready, 1);
    chk("stored_at_128", bus.pkts_stored, 1);
    chk("show_ahead_header", bus.rd_data, FE_HEADER);
    drain(128);
    chk("single_ready_clear", bus.pkt_ready, 0);
    chk("single_stored_clear", bus.pkts_stored, 0);
    for (int i = 0; i <= 50; i++) put(pw(2, i));
    send_pkt(3, 1'b1, 0);
    chk("trunc_cnt", bus.trunc_cnt, 1);
    chk("trunc_stored", bus.pkts_stored, 1);
    drain(128);
    for (int t = 4; t <= 8; t++) send_pkt(t, t < 8, 0);
    chk("overflow_stored", bus.pkts_stored, 4);
    chk("overflow_drop_cnt", bus.drop_cnt, 1);
    drain(512);
    chk("overflow_empty", bus.pkts_stored, 0);
    chk("overflow_ready_clear", bus.pkt_ready, 0);
    send_pkt(10, 1'b1, 0);
    send_pkt(11, 1'b1, 0);
    chk("two_stored", bus.pkts_stored, 2);
    fork
      send_pkt(12, 1'b1, 0);
      drain(128);
    join
    chk("commit_and_pop_same_cycle", bus.pkts_stored, 2);
    drain(256);
    chk("wrap_empty", bus.pkts_stored, 0);
    chk("drop_cnt_kept", bus.drop_cnt, 1);
    chk("trunc_cnt_kept", bus.trunc_cnt, 1);
    for (int i = 0; i < 60; i++) begin
      put(pw(13, i));
      repeat (2) @(negedge inclk);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge inclk);
    chk_idle("midpkt_reset");
    rst_n = 1'b1;
    @(negedge inclk);
    chk("post_reset_stored", bus.pkts_stored, 0);
    send_pkt(14, 1'b1, 0);
    chk("post_reset_ready", bus.pkt_ready, 1);
    chk("post_reset_stored_one", bus.pkts_stored, 1);
    drain(128);
    chk("post_reset_empty", bus.pkts_stored, 0);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
